// File: rtl/game_pkg.sv
// Shared game types and constants: state encoding, alien point values
// and the lives ceiling used by the HUD bookkeeping.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY    = 2'd1,
      RESPAWN = 2'd2,
      OVER    = 2'd3
   } game_state_t;

   localparam logic [6:0] PTS_TYPE0 = 7'd10;
   localparam logic [6:0] PTS_TYPE1 = 7'd20;
   localparam logic [6:0] PTS_TYPE2 = 7'd30;
   localparam logic [6:0] PTS_TYPE3 = 7'd100;

   localparam logic [1:0] MAX_LIVES = 2'd3;

   function automatic logic [6:0] kill_points(input logic [1:0] kill_type);
      logic [6:0] pts;
      case (kill_type)
         2'd0:    pts = PTS_TYPE0;
         2'd1:    pts = PTS_TYPE1;
         2'd2:    pts = PTS_TYPE2;
         default: pts = PTS_TYPE3;
      endcase
      return pts;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter clocked by frame ticks; done pulses on the tick
// that consumes the last remaining count.
module frame_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] load_val,
   input  logic       tick,
   output logic       done
);

   logic [7:0] count;

   // The counter parks at zero once expired so stray ticks do nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 8'd0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && (count != 8'd0)) begin
         count <= count - 8'd1;
      end
   end

   assign done = tick && !load && (count == 8'd1);

endmodule

// File: rtl/score_keeper.sv
// Score, lives and game-state bookkeeping feeding the HUD; every output
// comes straight from a register.
module score_keeper
   import game_pkg::*;
#(
   parameter int START_LIVES    = 3,
   parameter int RESPAWN_FRAMES = 90,
   parameter int SCORE_MAX      = 9999,
   parameter int BONUS_SCORE    = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic        start,
   input  logic        kill_valid,
   input  logic [1:0]  kill_type,
   input  logic        player_hit,
   output logic [13:0] score,
   output logic [1:0]  lives,
   output logic        playing,
   output logic        respawning,
   output logic        game_over
);

   game_state_t state, state_n;
   logic [13:0] score_n;
   logic [1:0]  lives_n;
   logic        bonus, bonus_n;
   logic        timer_load;
   logic        timer_done;
   logic [14:0] sum;

   frame_timer u_respawn_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (8'(RESPAWN_FRAMES)),
      .tick     (frame_tick && (state == RESPAWN)),
      .done     (timer_done)
   );

   assign sum = {1'b0, score} + {8'd0, kill_points(kill_type)};

   // Same-cycle events resolve in order: score, then bonus, then the hit,
   // so a bonus can rescue the last life.
   always_comb begin
      state_n    = state;
      score_n    = score;
      lives_n    = lives;
      bonus_n    = bonus;
      timer_load = 1'b0;

      case (state)
         IDLE, OVER: begin
            if (start) begin
               state_n = PLAY;
               score_n = 14'd0;
               lives_n = 2'(START_LIVES);
               bonus_n = 1'b0;
            end
         end
         PLAY, RESPAWN: begin
            if (kill_valid) begin
               if (sum > 15'(SCORE_MAX)) begin
                  score_n = 14'(SCORE_MAX);
               end else begin
                  score_n = sum[13:0];
               end
               if (!bonus && (score_n >= 14'(BONUS_SCORE))) begin
                  bonus_n = 1'b1;
                  if (lives < MAX_LIVES) begin
                     lives_n = lives + 2'd1;
                  end
               end
            end
            if (state == PLAY) begin
               if (player_hit) begin
                  if (lives_n <= 2'd1) begin
                     lives_n = 2'd0;
                     state_n = OVER;
                  end else begin
                     lives_n    = lives_n - 2'd1;
                     timer_load = 1'b1;
                     state_n    = RESPAWN;
                  end
               end
            end else if (timer_done) begin
               state_n = PLAY;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         score      <= 14'd0;
         lives      <= 2'(START_LIVES);
         bonus      <= 1'b0;
         playing    <= 1'b0;
         respawning <= 1'b0;
         game_over  <= 1'b0;
      end else begin
         state      <= state_n;
         score      <= score_n;
         lives      <= lives_n;
         bonus      <= bonus_n;
         playing    <= (state_n == PLAY) || (state_n == RESPAWN);
         respawning <= (state_n == RESPAWN);
         game_over  <= (state_n == OVER);
      end
   end

endmodule
